hsid_mse: RTL and testbench

HSID_MSE -- requirements
Module: hsid_mse

---
 rtl/hsid_mse.sv | 209 ++++++++++++++++++++
 tb/tb_hsid_mse.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hsid_mse.sv
// Mean squared error between a measured and a library spectrum, two 16-bit
// pixels per bus word, followed by a 48-cycle restoring divide by the band count.
module hsid_mse #(
    parameter int WORD_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_WIDTH_MUL = 32,
    parameter int DATA_WIDTH_ACC = 48,
    parameter int LENGTH_BITS    = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      start,
    input  logic [LENGTH_BITS-1:0]    vctr_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_WIDTH-1:0]     word_a,
    input  logic [WORD_WIDTH-1:0]     word_b,
    output logic                      busy,
    output logic                      mse_valid,
    output logic [DATA_WIDTH_MUL-1:0] mse_value,
    output logic [DATA_WIDTH_ACC-1:0] acc_value,
    output logic [2:0]                dbg_state
);

    localparam int CNT_W = $clog2(DATA_WIDTH_ACC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_DRAIN  = 3'd2,
        S_DIVIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                    state_q;
    logic [LENGTH_BITS-1:0]    len_q;
    logic [LENGTH_BITS-1:0]    remain_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [DATA_WIDTH_ACC-1:0] acc_q;
    logic [DATA_WIDTH_ACC-1:0] dvd_q;
    logic [LENGTH_BITS:0]      rem_q;
    logic                      mse_valid_q;
    logic [DATA_WIDTH_MUL-1:0] mse_value_q;
    logic [DATA_WIDTH_ACC-1:0] acc_value_q;

    logic [DATA_WIDTH-1:0]     d_lo_q, d_hi_q;
    logic                      v1_q;
    logic [DATA_WIDTH_MUL-1:0] sq_lo_q, sq_hi_q;
    logic                      v2_q;

    logic                      accept;
    logic [DATA_WIDTH-1:0]     a_lo, a_hi, b_lo, b_hi;
    logic [LENGTH_BITS:0]      rem_shift;
    logic                      rem_ge;
    logic [LENGTH_BITS:0]      rem_d;
    logic [DATA_WIDTH_ACC-1:0] dvd_d;

    function automatic logic [DATA_WIDTH-1:0] abs_diff(input logic [DATA_WIDTH-1:0] x,
                                                        input logic [DATA_WIDTH-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    assign a_lo = word_a[DATA_WIDTH-1:0];
    assign a_hi = word_a[2*DATA_WIDTH-1:DATA_WIDTH];
    assign b_lo = word_b[DATA_WIDTH-1:0];
    assign b_hi = word_b[2*DATA_WIDTH-1:DATA_WIDTH];

    assign in_ready  = (state_q == S_ACCUM) && (remain_q != '0);
    assign accept    = in_ready && in_valid && !clear;
    assign busy      = (state_q != S_IDLE);
    assign mse_valid = mse_valid_q;
    assign mse_value = mse_value_q;
    assign acc_value = acc_value_q;
    assign dbg_state = state_q;

    // One restoring-division step. The remainder is always below len_q, so its
    // top bit is zero in practice; folding it into the compare keeps the step exact.
    assign rem_shift = {rem_q[LENGTH_BITS-1:0], dvd_q[DATA_WIDTH_ACC-1]};
    assign rem_ge    = rem_q[LENGTH_BITS] || (rem_shift >= {1'b0, len_q});
    assign rem_d     = rem_ge ? (rem_shift - {1'b0, len_q}) : rem_shift;
    assign dvd_d     = {dvd_q[DATA_WIDTH_ACC-2:0], rem_ge};

    // Datapath stages 1 and 2; stage 3 is the accumulator in the control block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_lo_q  <= '0;
            d_hi_q  <= '0;
            v1_q    <= 1'b0;
            sq_lo_q <= '0;
            sq_hi_q <= '0;
            v2_q    <= 1'b0;
        end else if (clear) begin
            d_lo_q  <= '0;
            d_hi_q  <= '0;
            v1_q    <= 1'b0;
            sq_lo_q <= '0;
            sq_hi_q <= '0;
            v2_q    <= 1'b0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                d_lo_q <= abs_diff(a_lo, b_lo);
                // A single remaining element means an odd length: drop the upper half.
                d_hi_q <= (remain_q == LENGTH_BITS'(1)) ? '0 : abs_diff(a_hi, b_hi);
            end
            v2_q <= v1_q;
            if (v1_q) begin
                sq_lo_q <= DATA_WIDTH_MUL'(d_lo_q) * DATA_WIDTH_MUL'(d_lo_q);
                sq_hi_q <= DATA_WIDTH_MUL'(d_hi_q) * DATA_WIDTH_MUL'(d_hi_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            remain_q    <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            mse_valid_q <= 1'b0;
            mse_value_q <= '0;
            acc_value_q <= '0;
        end else if (clear) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            remain_q    <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            mse_valid_q <= 1'b0;
            mse_value_q <= '0;
            acc_value_q <= '0;
        end else begin
            mse_valid_q <= 1'b0;
            if (v2_q) begin
                acc_q <= acc_q + DATA_WIDTH_ACC'(sq_lo_q) + DATA_WIDTH_ACC'(sq_hi_q);
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (vctr_len != '0) begin
                            acc_q    <= '0;
                            len_q    <= vctr_len;
                            remain_q <= vctr_len;
                            state_q  <= S_ACCUM;
                        end else begin
                            acc_value_q <= '0;
                            mse_value_q <= '0;
                            mse_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        if (remain_q <= LENGTH_BITS'(2)) begin
                            remain_q <= '0;
                            cnt_q    <= '0;
                            state_q  <= S_DRAIN;
                        end else begin
                            remain_q <= remain_q - LENGTH_BITS'(2);
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= S_DIVIDE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DIVIDE: begin
                    // First DIVIDE cycle loads the settled accumulator, then one
                    // quotient bit per cycle for DATA_WIDTH_ACC cycles.
                    if (cnt_q == '0) begin
                        dvd_q <= acc_q;
                        rem_q <= '0;
                        cnt_q <= CNT_W'(1);
                    end else begin
                        dvd_q <= dvd_d;
                        rem_q <= rem_d;
                        if (cnt_q == CNT_W'(DATA_WIDTH_ACC)) begin
                            cnt_q       <= '0;
                            mse_value_q <= dvd_d[DATA_WIDTH_MUL-1:0];
                            acc_value_q <= acc_q;
                            mse_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsid_mse.sv
// Randomized bench for hsid_mse: each vector's sum of squared differences and
// mean are computed from the raw pixel arrays and compared at the result strobe.
module tb_hsid_mse;

    localparam int WW = 32;
    localparam int DW = 16;
    localparam int MW = 32;
    localparam int AW = 48;
    localparam int LB = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic [LB-1:0] vctr_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] word_a = '0;
    logic [WW-1:0] word_b = '0;
    logic          busy;
    logic          mse_valid;
    logic [MW-1:0] mse_value;
    logic [AW-1:0] acc_value;
    logic [2:0]    dbg_state;

    hsid_mse #(
        .WORD_WIDTH(WW), .DATA_WIDTH(DW), .DATA_WIDTH_MUL(MW),
        .DATA_WIDTH_ACC(AW), .LENGTH_BITS(LB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .vctr_len(vctr_len), .in_valid(in_valid), .in_ready(in_ready),
        .word_a(word_a), .word_b(word_b), .busy(busy), .mse_valid(mse_valid),
        .mse_value(mse_value), .acc_value(acc_value), .dbg_state(dbg_state)
    );

    // Clock and edge counter: at a negedge, cyc equals the number of rising edges so far.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WW-1:0] a_mem[512];
    logic [WW-1:0] b_mem[512];
    logic [63:0]   exp_acc_q[$];
    logic [63:0]   exp_mse_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: sum over the first len pixels of (a-b)^2, element i in word i/2, half i%2.
    function automatic logic [63:0] model_acc(input int len);
        longint unsigned sum;
        logic [WW-1:0]   wa, wb;
        longint unsigned ea, eb, diff;
        sum = 0;
        for (int i = 0; i < len; i++) begin
            wa = a_mem[i / 2];
            wb = b_mem[i / 2];
            ea = (i % 2 == 1) ? longint'(wa[31:16]) : longint'(wa[15:0]);
            eb = (i % 2 == 1) ? longint'(wb[31:16]) : longint'(wb[15:0]);
            diff = (ea > eb) ? ea - eb : eb - ea;
            sum += diff * diff;
        end
        return sum;
    endfunction

    // Driver + scoreboard for one vector. rst_at > 0 asserts rst_n that many
    // cycles after the final word is accepted and abandons the vector.
    task automatic run_vector(input int len, input int gap_pct, input int rst_at);
        int          nwords, idx, last, lat, exp_lat;
        bit          got, saw_ready;
        logic [63:0] e_acc, e_mse, pa, pm;
        nwords = (len + 1) / 2;
        idx = 0;
        got = 0;
        saw_ready = 0;
        e_acc = model_acc(len);
        e_mse = (len == 0) ? 64'd0 : e_acc / 64'(len);
        exp_acc_q.push_back(e_acc);
        exp_mse_q.push_back(e_mse);
        exp_lat = (len == 0) ? 0 : 51;
        @(negedge clk);
        start = 1'b1;
        vctr_len = LB'(len);
        last = cyc + 1;
        for (int t = 0; t < 8000 && !got; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (in_ready) saw_ready = 1;
            if (rst_at > 0 && idx == nwords && cyc - last == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_in_ready", 64'(in_ready), 64'd0);
                check("rst_mse_valid", 64'(mse_valid), 64'd0);
                check("rst_mse_value", 64'(mse_value), 64'd0);
                check("rst_acc_value", 64'(acc_value), 64'd0);
                check("rst_state", 64'(dbg_state), 64'd0);
                void'(exp_acc_q.pop_back());
                void'(exp_mse_q.pop_back());
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (mse_valid) begin
                got = 1;
                lat = cyc - last;
                pa = exp_acc_q.pop_front();
                pm = exp_mse_q.pop_front();
                check("latency", 64'(lat), 64'(exp_lat));
                check("acc_value", 64'(acc_value), pa);
                check("mse_value", 64'(mse_value), pm);
            end else if (idx < nwords && $urandom_range(0, 99) >= gap_pct) begin
                in_valid = 1'b1;
                word_a = a_mem[idx];
                word_b = b_mem[idx];
                if (in_ready) begin
                    idx++;
                    last = cyc + 1;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (!got) begin
            check("mse_valid_timeout", 64'd0, 64'd1);
            void'(exp_acc_q.pop_front());
            void'(exp_mse_q.pop_front());
            return;
        end
        if (len == 0) check("len0_in_ready", 64'(saw_ready), 64'd0);
        @(negedge clk);
        check("strobe_width", 64'(mse_valid), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic clear_run();
        bit seen;
        seen = 0;
        a_mem[0] = 32'h1234_0042;
        b_mem[0] = 32'h0011_0007;
        @(negedge clk);
        start = 1'b1;
        vctr_len = LB'(4);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        word_a = a_mem[0];
        word_b = b_mem[0];
        check("clr_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_acc_value", 64'(acc_value), 64'd0);
        check("clr_mse_value", 64'(mse_value), 64'd0);
        for (int t = 0; t < 70; t++) begin
            @(negedge clk);
            if (mse_valid) seen = 1;
        end
        check("clr_no_strobe", 64'(seen), 64'd0);
    endtask

    initial begin
        int len, gap;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_mse_valid", 64'(mse_valid), 64'd0);
        check("reset_acc_value", 64'(acc_value), 64'd0);
        rst_n = 1'b1;

        a_mem[0] = 32'h0003_0005; b_mem[0] = 32'h0001_0001;
        run_vector(2, 0, 0);
        repeat (3) @(negedge clk);
        check("hold_acc", 64'(acc_value), 64'd20);
        check("hold_mse", 64'(mse_value), 64'd10);

        a_mem[0] = 32'h0002_0002; b_mem[0] = 32'h0;
        a_mem[1] = 32'hFFFF_0003; b_mem[1] = 32'h0;
        run_vector(3, 30, 0);

        a_mem[0] = 32'h0000_0000; b_mem[0] = 32'h0000_FFFF;
        run_vector(1, 0, 0);

        run_vector(0, 0, 0);

        a_mem[0] = 32'h0003_0005; b_mem[0] = 32'h0001_0001;
        run_vector(2, 0, 0);
        clear_run();
        a_mem[0] = 32'h0003_0005; b_mem[0] = 32'h0001_0001;
        run_vector(2, 0, 0);

        for (int i = 0; i < 512; i++) begin
            a_mem[i] = 32'hFFFF_FFFF;
            b_mem[i] = 32'h0;
        end
        run_vector(1023, 0, 0);

        for (int i = 0; i < 5; i++) begin
            a_mem[i] = $urandom;
            b_mem[i] = $urandom;
        end
        run_vector(10, 20, 20);

        for (int v = 0; v < 200; v++) begin
            len = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 48));
            gap = $urandom_range(0, 50);
            for (int i = 0; i < 25; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    a_mem[i] = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
                    b_mem[i] = ~a_mem[i];
                end else begin
                    a_mem[i] = $urandom;
                    b_mem[i] = $urandom;
                end
            end
            run_vector(len, gap, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
